// File: rtl/strhw_digest_serializer.sv
// strhw_digest_serializer
// Takes a finished 512-bit Streebog hash state and emits it as a stream of
// WORD_W-bit words, least significant word first. In Streebog-256 mode only
// the upper 256 bits are emitted.
// Optional build macro: STRHW_DIGEST_BYTE_REVERSE_EN reverses the byte order
// inside every emitted word (word order and timing are unchanged).

package strhw_digest_serializer_pkg;
  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,  // idle, accepting a digest
    ST_BUSY  = 2'd1,  // loading: counter cleared, first word selected
    ST_READY = 2'd2,  // presenting words
    ST_DONE  = 2'd3   // one-cycle wrap-up
  } state_t;
endpackage

module strhw_digest_serializer
  import strhw_digest_serializer_pkg::*;
#(
  parameter int WORD_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [511:0]      digest_i,
  input  logic              mode256_i,
  input  logic              digest_valid_i,
  output logic              digest_ready_o,
  output logic [WORD_W-1:0] word_o,
  output logic              word_valid_o,
  input  logic              word_ready_i,
  output logic              word_last_o,
  output state_t            state_o
);

  localparam int N512  = 512 / WORD_W;
  localparam int N256  = 256 / WORD_W;
  localparam int CNT_W = (N512 > 1) ? $clog2(N512) : 1;
  localparam logic [CNT_W-1:0] LAST512 = CNT_W'(N512 - 1);
  localparam logic [CNT_W-1:0] LAST256 = CNT_W'(N256 - 1);

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [511:0]        data_q, data_d;
  logic                mode_q, mode_d;
  logic [WORD_W-1:0]   word_q, word_d;
  logic                valid_q, valid_d;
  logic                last_q, last_d;
  logic                dready_q, dready_d;
  logic [8:0]          sel_lsb;
  logic [WORD_W-1:0]   raw_word;

  // Output formatting of one word: optional byte swap, otherwise pass-through.
  function automatic logic [WORD_W-1:0] fmt_word(input logic [WORD_W-1:0] w);
    logic [WORD_W-1:0] r;
`ifdef STRHW_DIGEST_BYTE_REVERSE_EN
    r = '0;
    for (int b = 0; b < WORD_W / 8; b++) begin
      r[b*8 +: 8] = w[WORD_W-8-b*8 +: 8];
    end
`else
    r = w;
`endif
    return r;
  endfunction

  // Next-state, capture and counter logic; outputs are derived from the next
  // state so that they come straight out of flops.
  always_comb begin
    // NOTE: every signal written here gets a default first; a path that leaves
    // one unassigned would infer a latch.
    state_d  = state_q;
    cnt_d    = cnt_q;
    data_d   = data_q;
    mode_d   = mode_q;
    sel_lsb  = '0;
    raw_word = '0;

    unique case (state_q)
      ST_CLEAR: begin
        if (digest_valid_i && dready_q) begin
          data_d  = digest_i;
          mode_d  = mode256_i;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        cnt_d   = '0;
        state_d = ST_READY;
      end
      ST_READY: begin
        if (valid_q && word_ready_i) begin
          if (last_q) begin
            state_d = ST_DONE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_CLEAR;
      end
      default: begin
        state_d = ST_CLEAR;
      end
    endcase

    // Word k starts at bit base + k*WORD_W, base = 256 in 256-bit mode.
    sel_lsb  = {mode_d, 8'd0} + 9'(cnt_d) * 9'(WORD_W);
    raw_word = data_d[sel_lsb +: WORD_W];

    valid_d  = (state_d == ST_READY);
    word_d   = valid_d ? fmt_word(raw_word) : '0;
    last_d   = valid_d && (cnt_d == (mode_d ? LAST256 : LAST512));
    dready_d = (state_d == ST_CLEAR);
  end

  // State and output registers with synchronous reset that wins over any
  // handshake in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: sequential state is updated with non-blocking assignments only,
      // so every flop samples the pre-edge values regardless of statement order.
      state_q  <= ST_CLEAR;
      cnt_q    <= '0;
      // NOTE: the wide capture register is reset too, so a digest aborted by
      // reset never lingers in the datapath.
      data_q   <= '0;
      mode_q   <= 1'b0;
      word_q   <= '0;
      valid_q  <= 1'b0;
      last_q   <= 1'b0;
      dready_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      data_q   <= data_d;
      mode_q   <= mode_d;
      word_q   <= word_d;
      valid_q  <= valid_d;
      last_q   <= last_d;
      dready_q <= dready_d;
    end
  end

  assign digest_ready_o = dready_q;
  assign word_o         = word_q;
  assign word_valid_o   = valid_q;
  assign word_last_o    = last_q;
  assign state_o        = state_q;

endmodule

// File: tb/tb_strhw_digest_serializer.sv
// Self-checking bench for strhw_digest_serializer (WORD_W = 64).
// Expected words come from a queue filled by a reference model that slices
// the accepted digest arithmetically; a negedge monitor checks every transfer,
// stall stability and idle outputs.

module tb_strhw_digest_serializer;
  import strhw_digest_serializer_pkg::*;

  localparam int WORD_W = 64;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [511:0]      digest_i = '0;
  logic              mode256_i = 1'b0;
  logic              digest_valid_i = 1'b0;
  logic              digest_ready_o;
  logic [WORD_W-1:0] word_o;
  logic              word_valid_o;
  logic              word_ready_i = 1'b0;
  logic              word_last_o;
  state_t            state_o;

  strhw_digest_serializer #(.WORD_W(WORD_W)) dut (
    .clk            (clk),
    .rst            (rst),
    .digest_i       (digest_i),
    .mode256_i      (mode256_i),
    .digest_valid_i (digest_valid_i),
    .digest_ready_o (digest_ready_o),
    .word_o         (word_o),
    .word_valid_o   (word_valid_o),
    .word_ready_i   (word_ready_i),
    .word_last_o    (word_last_o),
    .state_o        (state_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [WORD_W-1:0] w;
    logic              last;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   xfer_cnt = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: word k is the k-th WORD_W slice above the mode's base bit.
  function automatic logic [WORD_W-1:0] model_word(input logic [511:0] d, input logic m, input int k);
    logic [511:0]      sh;
    logic [WORD_W-1:0] w;
    sh = d >> ((m ? 256 : 0) + k * WORD_W);
    w  = sh[WORD_W-1:0];
`ifdef STRHW_DIGEST_BYTE_REVERSE_EN
    w  = {<<8{w}};
`endif
    return w;
  endfunction

  task automatic push_digest(input logic [511:0] d, input logic m);
    int n;
    n = (m ? 256 : 512) / WORD_W;
    for (int k = 0; k < n; k++) exp_q.push_back('{w: model_word(d, m, k), last: (k == n - 1)});
  endtask

  function automatic logic [511:0] rand512();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // One clock: record an accept handshake seen before the edge, return #1 after it.
  task automatic step();
    logic         acc;
    logic [511:0] d;
    logic         m;
    acc = !rst && digest_valid_i && digest_ready_o;
    d   = digest_i;
    m   = mode256_i;
    @(posedge clk);
    #1;
    if (acc) begin
      push_digest(d, m);
      digest_valid_i = 1'b0;
    end
  endtask

  // Offer a digest and return right after it is accepted; inputs are then scrambled.
  task automatic send(input logic [511:0] d, input logic m);
    digest_i       = d;
    mode256_i      = m;
    digest_valid_i = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (digest_ready_o) begin
        step();
        digest_i  = rand512();
        mode256_i = 1'($urandom);
        return;
      end
      step();
    end
    check("accept_timeout", 1, 0);
    digest_valid_i = 1'b0;
  endtask

  // Run until all expected words are out and the DUT is idle.
  // rdy_mode: 0 = always ready, 1 = pattern 1,0,0,1, 2 = random.
  task automatic drain(input int rdy_mode);
    for (int i = 0; i < 1000; i++) begin
      if (exp_q.size() == 0 && state_o == ST_CLEAR && !word_valid_o && !digest_valid_i) return;
      case (rdy_mode)
        0:       word_ready_i = 1'b1;
        1:       word_ready_i = (i % 4 == 0) || (i % 4 == 3);
        default: word_ready_i = ($urandom % 4) != 0;
      endcase
      step();
    end
    check("drain_timeout", 1, 0);
  endtask

  // Monitor: transfers against the model, stall stability, idle zeroing.
  logic              prev_stall = 1'b0;
  logic [WORD_W-1:0] prev_word;
  logic              prev_last;
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      check("valid_vs_state", word_valid_o, state_o == ST_READY);
      check("dready_outside_clear", digest_ready_o && (state_o != ST_CLEAR), 0);
      if (prev_stall)
        check("stall_hold", {word_valid_o, word_last_o, word_o}, {1'b1, prev_last, prev_word});
      if (!word_valid_o) begin
        check("idle_zero", word_o, 0);
      end else if (word_ready_i) begin
        if (exp_q.size() == 0) begin
          check("unexpected_word", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("word", word_o, e.w);
          check("last", word_last_o, e.last);
        end
        xfer_cnt++;
      end
      prev_stall = word_valid_o && !word_ready_i;
      prev_word  = word_o;
      prev_last  = word_last_o;
    end
  end

  initial begin
    logic [511:0] d_inc;
    state_t       seq[11];
    int           base;

    for (int k = 0; k < 8; k++) d_inc[k*64 +: 64] = 64'(k);

    // Reset behaviour.
    rst = 1'b1;
    step();
    step();
    check("rst_dready", digest_ready_o, 0);
    check("rst_state", state_o, ST_CLEAR);
    check("rst_outputs", {word_valid_o, word_last_o, word_o}, 0);
    rst = 1'b0;
    step();
    check("dready_after_rst", digest_ready_o, 1);

    // 512-bit mode, counting digest, always ready: exact state sequence.
    seq[0]  = ST_BUSY;
    for (int i = 1; i <= 8; i++) seq[i] = ST_READY;
    seq[9]  = ST_DONE;
    seq[10] = ST_CLEAR;
    word_ready_i = 1'b1;
    base = xfer_cnt;
    send(d_inc, 1'b0);
    for (int i = 0; i < 11; i++) begin
      check($sformatf("seq%0d", i), state_o, seq[i]);
      if (i == 1) check("first_valid_latency", word_valid_o, 1);
      step();
    end
    check("count512", xfer_cnt - base, 8);
    drain(0);

    // 256-bit mode: words 4..7 only.
    base = xfer_cnt;
    send(d_inc, 1'b1);
    drain(0);
    check("count256", xfer_cnt - base, 4);

    // Stall pattern 1,0,0,1.
    base = xfer_cnt;
    word_ready_i = 1'b0;
    send(rand512(), 1'b0);
    drain(1);
    check("count_stall", xfer_cnt - base, 8);

    // Reset one cycle after the third transfer aborts the digest.
    word_ready_i = 1'b1;
    base = xfer_cnt;
    send(rand512(), 1'b0);
    for (int i = 0; i < 20 && xfer_cnt < base + 3; i++) step();
    check("three_xfers", xfer_cnt - base, 3);
    rst = 1'b1;
    step();
    rst = 1'b0;
    exp_q.delete();
    check("abort_valid", word_valid_o, 0);
    check("abort_state", state_o, ST_CLEAR);
    send(d_inc, 1'b0);
    drain(0);

    // New digest held valid during READY is ignored until CLEAR.
    word_ready_i = 1'b0;
    base = xfer_cnt;
    send(d_inc, 1'b0);
    digest_i       = {512{1'b1}};
    mode256_i      = 1'b0;
    digest_valid_i = 1'b1;
    for (int i = 0; i < 5; i++) step();
    check("held_not_clear", state_o != ST_CLEAR, 1);
    drain(2);
    check("count_two_digests", xfer_cnt - base, 16);

    // Byte order of word 0.
    word_ready_i = 1'b1;
    d_inc[63:0] = 64'h0102030405060708;
    send(d_inc, 1'b0);
    step();
`ifdef STRHW_DIGEST_BYTE_REVERSE_EN
    check("byte_order_w0", word_o, 64'h0807060504030201);
`else
    check("byte_order_w0", word_o, 64'h0102030405060708);
`endif
    drain(0);

    // Randomized digests, modes and backpressure.
    for (int n = 0; n < 25; n++) begin
      word_ready_i = 1'($urandom);
      send(rand512(), 1'($urandom));
      drain(2);
    end

    check("final_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/strhw_digest_serializer.md
STRHW_DIGEST_SERIALIZER -- requirements
Module: strhw_digest_serializer

Interface
REQ-001 SHALL have parameter WORD_W, default 64, output word width in bits; legal values 8, 32, 64, 128.
REQ-002 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port digest_i  input  512  (uint512) finished Streebog hash state from the compression core.
REQ-005 SHALL have port mode256_i  input  1  1 = Streebog-256 (emit upper 256 bits), 0 = Streebog-512.
REQ-006 SHALL have port digest_valid_i  input  1  digest_i/mode256_i valid.
REQ-007 SHALL have port digest_ready_o  output  1  serializer can accept a digest.
REQ-008 SHALL have port word_o  output  WORD_W  current output word.
REQ-009 SHALL have port word_valid_o  output  1  word_o valid.
REQ-010 SHALL have port word_ready_i  input  1  downstream accepts word_o.
REQ-011 SHALL have port word_last_o  output  1  word_o is the final word of the digest.
REQ-012 SHALL have port state_o  output  2  current state, encoded as the package state_t.

Function
REQ-013 SHALL implement FSM using state_t: CLEAR (idle), BUSY (load), READY (presenting words), DONE (wrap-up).
REQ-014 SHALL assert digest_ready_o only in CLEAR.
REQ-015 SHALL capture digest_i and mode256_i into internal registers on digest_valid_i && digest_ready_o, then go CLEAR->BUSY.
REQ-016 SHALL spend exactly one cycle in BUSY (word counter cleared, first word selected), then go READY; first word_valid_o appears 2 cycles after accept.
REQ-017 SHALL set word count N = 512/WORD_W (mode 512) or 256/WORD_W (mode 256).
REQ-018 SHALL emit word k (k = 0..N-1) = captured bits [base + (k+1)*WORD_W-1 : base + k*WORD_W], base = 256 in mode 256, 0 in mode 512 (least significant word first).
REQ-019 SHALL assert word_valid_o only in READY; a word transfers on word_valid_o && word_ready_i.
REQ-020 SHALL hold word_o, word_last_o and word_valid_o stable while word_valid_o && !word_ready_i.
REQ-021 SHALL advance the counter by one per transfer; word_last_o high when counter == N-1, otherwise low.
REQ-022 SHALL go READY->DONE on the transfer with word_last_o high, remain in DONE exactly one cycle, then go CLEAR.
REQ-023 SHALL drive word_o to zero whenever word_valid_o is low.
REQ-024 SHALL ignore digest_valid_i and changes of digest_i/mode256_i outside CLEAR; captured values are used for the whole transfer.
REQ-025 SHALL sustain one word per cycle while word_ready_i is held high; back-to-back digests are separated by DONE+CLEAR+BUSY (3 idle output cycles minimum).

Reset
REQ-026 SHALL on rst force state CLEAR, counter 0, captured digest 0, mode 0; outputs: digest_ready_o=1 after the first cycle with rst low (0 while rst high), word_valid_o=0, word_last_o=0, word_o=0, state_o=CLEAR.
REQ-027 SHALL abort any transfer in progress on rst without emitting further words; rst dominates simultaneous handshakes.

Configuration
REQ-028 SHALL honour macro STRHW_DIGEST_BYTE_REVERSE_EN: when defined, each emitted word has its byte order reversed (byte 0 <-> byte WORD_W/8-1); word order and all timing unchanged.
REQ-029 SHALL, without STRHW_DIGEST_BYTE_REVERSE_EN, emit words unmodified per REQ-018; WORD_W=8 makes both builds identical.

Verification
REQ-030 SHALL cover: WORD_W=64, mode 512, digest word k = 64'h0000_0000_0000_000k, word_ready_i=1 -> words 0..7 in order on 8 consecutive cycles, word_last_o only on word 7, state sequence CLEAR,BUSY,READY x8,DONE,CLEAR.
REQ-031 SHALL cover: same digest, mode256_i=1 -> exactly 4 words 4,5,6,7, word_last_o on value 7.
REQ-032 SHALL cover: word_ready_i toggled 1,0,0,1 repeating -> no word lost or duplicated, word_o stable across stall cycles.
REQ-033 SHALL cover: rst pulsed for 1 cycle after 3rd word transfer -> word_valid_o=0 next cycle, state CLEAR, next digest serialized from word 0.
REQ-034 SHALL cover: digest_valid_i held high with new digest 512'hFF..FF during READY -> ignored; original words complete, new digest accepted only after return to CLEAR.
REQ-035 SHALL cover: STRHW_DIGEST_BYTE_REVERSE_EN defined, WORD_W=64, word 0 = 64'h0102030405060708 -> word_o = 64'h0807060504030201.
